hc21_ste_busarb: RTL and testbench
==================================

# hc21_ste_busarb

STE bus-master arbiter and CPU bus-handover sequencer for the HC21 STE card. Shares the on-card CPU's bus between two external STE masters (busrq_n[1:0]): requests the bus from the CPU, waits for the CPU's acknowledge, grants exactly one requester with round-robin fairness, and hands the bus back when the requester releases. It sits between the STE backplane request/acknowledge lines and the CPU BUSRQ/BUSAK pins. It replaces the combinational request/acknowledge path in the interrupt handler.

## Interface
- TIMEOUT_CYCLES, 4096: maximum grant length in sysclk cycles before forced release. Legal range is 2 or more.
- CNT_W, $clog2(TIMEOUT_CYCLES): width of the timeout counter.

- sysclk  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous reset, active-high.
- busrq_n  in  2  STE bus requests from the backplane, active-low. Asynchronous to sysclk.
- cpu_busak_n  in  1  CPU bus acknowledge, active-low. Synchronous to sysclk.
- cpu_busrq_n  out  1  bus request to the CPU, active-low, registered.
- busak_n  out  2  STE bus acknowledges, active-low, registered, one-hot-low or 2'b11.
- grant_id  out  1  index of the current or last granted requester.
- bus_busy  out  1  high in every state except IDLE.
- bus_timeout  out  1  one-cycle pulse on forced release. Present only with the macro defined.

## Operation
- Synchronisation:
  - busrq_n passes through a 2-flop synchroniser; the output is req_s[1:0], active-high.
  - Synchroniser flops reset to "not requesting".
  - cpu_busak_n is registered once to give ack_s.
- States: IDLE, REQ_CPU, GRANT, RELEASE, WAIT_CPU.
- IDLE:
  - cpu_busrq_n=1, busak_n=2'b11.
  - Any eligible req_s → REQ_CPU.
- REQ_CPU:
  - cpu_busrq_n=0.
  - On ack_s: if any eligible req_s, select the winner → GRANT. Otherwise (the requester withdrew) → RELEASE.
- Winner selection:
  - A single eligible request wins.
  - If both are eligible, the index ≠ last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - grant_id and last_grant update on entry to GRANT.
- GRANT:
  - busak_n[grant_id]=0, cpu_busrq_n=0.
  - Stay while req_s[grant_id] is high.
  - The other requester asserting has no effect.
  - When req_s[grant_id] drops → RELEASE.
- RELEASE:
  - busak_n=2'b11, cpu_busrq_n=1.
  - Unconditional → WAIT_CPU.
- WAIT_CPU:
  - Hold outputs deasserted until ack_s is low (CPU has retaken the bus) → IDLE.
  - A pending request is then serviced from IDLE. There is at least one IDLE cycle between grants.
- ack_s dropping during GRANT (CPU protocol violation) is ignored. The grant holds.
- Reset values:
  - cpu_busrq_n=1, busak_n=2'b11, grant_id=0, bus_busy=0, bus_timeout=0.
  - State=IDLE, last_grant=1, counter=0, lockout=2'b00.
- Reset mid-grant: all outputs return to reset values at the reset edge. No RELEASE sequence is run.

## Timing
- From busrq_n falling (setup met before edge E0):
  - req_s is high after edge E1.
  - REQ_CPU is entered and cpu_busrq_n goes low after E2.
- From cpu_busak_n falling before edge A0:
  - ack_s is high after A0.
  - GRANT is entered and busak_n goes low after A1.
- From busrq_n rising before edge R0:
  - req_s drops after R1.
  - RELEASE (busak_n=11, cpu_busrq_n=1) after R2.
  - WAIT_CPU after R3.
- From cpu_busak_n rising before W0: IDLE after W1.
- busak_n and cpu_busrq_n never change in the same cycle as the state decision. All outputs come straight from registers.

## Configuration
- HC21_ARB_TIMEOUT_EN defined — grant watchdog compiled in:
  - The counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 → RELEASE, and bus_timeout pulses for one cycle coincident with entry to RELEASE.
  - lockout[grant_id] is then set. A locked requester is ineligible until its req_s is seen low, which clears the lockout.
- Not defined:
  - No counter, no lockout, and the bus_timeout port is absent.
  - GRANT lasts indefinitely until the requester releases.

## Test plan
- Single requester: busrq_n=2'b10 → cpu_busrq_n low 2 cycles later. Hold cpu_busak_n low → busak_n=2'b10 2 cycles after. Release busrq_n → busak_n=2'b11 and cpu_busrq_n=1 2 cycles later. Return cpu_busak_n high → IDLE.
- Round-robin: both busrq_n held low continuously → grants alternate 0,1,0,1. There is always at least one IDLE cycle between grants, and busak_n is never 2'b00.
- Withdrawal: busrq_n[1] pulsed low for 4 cycles, CPU acks after 10 cycles → no busak_n assertion, RELEASE → WAIT_CPU → IDLE.
- Timeout (macro on, TIMEOUT_CYCLES=16): requester 0 holds indefinitely → busak_n[0] low for exactly 16 cycles, one bus_timeout pulse. Requester 0 is not re-granted until busrq_n[0] goes high and then low again.
- Reset mid-grant: assert reset during GRANT → next edge busak_n=2'b11, cpu_busrq_n=1, bus_busy=0. The next tie goes to requester 0.
- Macro off: hold a grant for 10000 cycles → busak_n stays low and no forced release occurs.

Source files
------------

// File: rtl/hc21_ste_busarb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hc21_ste_busarb                                            |
// | Description : STE bus-master arbiter and CPU bus-handover sequencer.     |
// |               Requests the bus from the on-card CPU, grants one of two   |
// |               backplane masters round-robin, hands the bus back on       |
// |               release.                                                   |
// |               Optional macro HC21_ARB_TIMEOUT_EN adds a grant watchdog,  |
// |               per-requester lockout and the bus_timeout pulse output.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hc21_ste_busarb #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [1:0] busrq_n,
    input  logic       cpu_busak_n,
    output logic       cpu_busrq_n,
    output logic [1:0] busak_n,
    output logic       grant_id,
    output logic       bus_busy
`ifdef HC21_ARB_TIMEOUT_EN
    ,
    output logic       bus_timeout
`endif
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_req_cpu  = 3'd1;
    localparam logic [2:0] c_st_grant    = 3'd2;
    localparam logic [2:0] c_st_release  = 3'd3;
    localparam logic [2:0] c_st_wait_cpu = 3'd4;

    // Elaboration-time sanity check on the watchdog length
    if (TIMEOUT_CYCLES < 2 || CNT_W < 1) begin : g_cfg_check
        $error("hc21_ste_busarb: TIMEOUT_CYCLES must be 2 or more");
    end

    logic [1:0] r_req_meta;
    logic [1:0] r_req_s;
    logic       r_ack_s;
    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       r_last_grant;
    logic       r_grant_id;
    logic       r_cpu_busrq_n;
    logic [1:0] r_busak_n;
    logic       r_bus_busy;
    logic [1:0] w_elig;
    logic       w_winner;
    logic       w_enter_grant;
    logic       w_gid_nxt;
    logic       w_cpu_busrq_n_nxt;
    logic [1:0] w_busak_n_nxt;
    logic       w_bus_busy_nxt;

    // Two-flop synchroniser for the asynchronous backplane requests, one flop for the CPU ack
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_req_meta <= 2'b00;
            r_req_s    <= 2'b00;
            r_ack_s    <= 1'b0;
        end else begin
            r_req_meta <= ~busrq_n;
            r_req_s    <= r_req_meta;
            r_ack_s    <= ~cpu_busak_n;
        end
    end

`ifdef HC21_ARB_TIMEOUT_EN
    logic [1:0]       r_lockout;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_timeout;
    logic             w_to_hit;

    assign w_elig   = r_req_s & ~r_lockout;
    assign w_to_hit = (r_state == c_st_grant) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Grant watchdog: count GRANT cycles, lock out a requester that overstays until it lets go
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_lockout     <= 2'b00;
            r_bus_timeout <= 1'b0;
        end else begin
            r_bus_timeout <= w_to_hit;
            if (w_enter_grant) begin
                r_cnt <= '0;
            end else if (r_state == c_st_grant) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Setting wins over the clear so a forced-off requester is always locked at least once
            r_lockout <= (r_lockout & r_req_s) |
                         (w_to_hit ? (r_grant_id ? 2'b10 : 2'b01) : 2'b00);
        end
    end

    assign bus_timeout = r_bus_timeout;
`else
    assign w_elig = r_req_s;
`endif

    // Next-state, winner selection and next registered output values
    always_comb begin
        w_state_nxt = r_state;
        w_winner    = 1'b0;
        if (w_elig == 2'b10) begin
            w_winner = 1'b1;
        end else if (w_elig == 2'b11) begin
            w_winner = ~r_last_grant;
        end

        case (r_state)
            c_st_idle: begin
                if (|w_elig) w_state_nxt = c_st_req_cpu;
            end
            c_st_req_cpu: begin
                if (r_ack_s) w_state_nxt = (|w_elig) ? c_st_grant : c_st_release;
            end
            c_st_grant: begin
                // A CPU ack drop here is a protocol violation and is deliberately ignored
                if (!r_req_s[r_grant_id]) w_state_nxt = c_st_release;
`ifdef HC21_ARB_TIMEOUT_EN
                if (w_to_hit) w_state_nxt = c_st_release;
`endif
            end
            c_st_release: begin
                w_state_nxt = c_st_wait_cpu;
            end
            c_st_wait_cpu: begin
                if (!r_ack_s) w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        w_enter_grant     = (r_state == c_st_req_cpu) && (w_state_nxt == c_st_grant);
        w_gid_nxt         = w_enter_grant ? w_winner : r_grant_id;
        w_cpu_busrq_n_nxt = !((w_state_nxt == c_st_req_cpu) || (w_state_nxt == c_st_grant));
        w_busak_n_nxt     = 2'b11;
        if (w_state_nxt == c_st_grant) begin
            w_busak_n_nxt = w_gid_nxt ? 2'b01 : 2'b10;
        end
        w_bus_busy_nxt    = (w_state_nxt != c_st_idle);
    end

    // State register plus output registers loaded from the next-state decode
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_last_grant  <= 1'b1;
            r_grant_id    <= 1'b0;
            r_cpu_busrq_n <= 1'b1;
            r_busak_n     <= 2'b11;
            r_bus_busy    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant_id    <= w_gid_nxt;
            if (w_enter_grant) r_last_grant <= w_winner;
            r_cpu_busrq_n <= w_cpu_busrq_n_nxt;
            r_busak_n     <= w_busak_n_nxt;
            r_bus_busy    <= w_bus_busy_nxt;
        end
    end

    assign cpu_busrq_n = r_cpu_busrq_n;
    assign busak_n     = r_busak_n;
    assign grant_id    = r_grant_id;
    assign bus_busy    = r_bus_busy;

endmodule
`default_nettype wire

// File: tb/tb_hc21_ste_busarb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hc21_ste_busarb                                         |
// | Description : Self-checking bench for hc21_ste_busarb. Directed timing   |
// |               scenarios plus randomized requesters checked against a     |
// |               transaction-level arbitration model. HC21_ARB_TIMEOUT_EN   |
// |               selects the watchdog scenario.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_hc21_ste_busarb;

`ifdef HC21_ARB_TIMEOUT_EN
    localparam int c_to = 16;
`else
    localparam int c_to = 4096;
`endif

    logic       sysclk = 1'b0;
    logic       reset;
    logic [1:0] busrq_n;
    logic       cpu_busak_n;
    logic       cpu_busrq_n;
    logic [1:0] busak_n;
    logic       grant_id;
    logic       bus_busy;
`ifdef HC21_ARB_TIMEOUT_EN
    logic       bus_timeout;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic       cpu_auto = 1'b0;
    int         cpu_dly = 0;
    logic       model_last;
    logic [1:0] hist [0:2047];

    hc21_ste_busarb #(
        .TIMEOUT_CYCLES(c_to)
    ) u_dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .busrq_n     (busrq_n),
        .cpu_busak_n (cpu_busak_n),
        .cpu_busrq_n (cpu_busrq_n),
        .busak_n     (busak_n),
        .grant_id    (grant_id),
        .bus_busy    (bus_busy)
`ifdef HC21_ARB_TIMEOUT_EN
        ,
        .bus_timeout (bus_timeout)
`endif
    );

    always #5 sysclk = ~sysclk;

    // One clock; outputs are stable 1ns after the edge. An automatic CPU follows
    // cpu_busrq_n with a small random latency when enabled.
    task automatic step();
        @(posedge sysclk);
        #1;
        if (cpu_auto && (cpu_busak_n !== cpu_busrq_n)) begin
            if (cpu_dly == 0) begin
                cpu_busak_n = cpu_busrq_n;
                cpu_dly     = $urandom_range(0, 2);
            end else begin
                cpu_dly = cpu_dly - 1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; busrq_n = 2'b11; cpu_busak_n = 1'b1; cpu_auto = 1'b0;
        repeat (3) step();
        n_cmp++; if (cpu_busrq_n !== 1'b1) begin n_err++; $display("FAIL reset_cpu_busrq_n: got %b expected 1", cpu_busrq_n); end
        n_cmp++; if (busak_n !== 2'b11) begin n_err++; $display("FAIL reset_busak_n: got %b expected 11", busak_n); end
        n_cmp++; if (grant_id !== 1'b0) begin n_err++; $display("FAIL reset_grant_id: got %b expected 0", grant_id); end
        n_cmp++; if (bus_busy !== 1'b0) begin n_err++; $display("FAIL reset_bus_busy: got %b expected 0", bus_busy); end
`ifdef HC21_ARB_TIMEOUT_EN
        n_cmp++; if (bus_timeout !== 1'b0) begin n_err++; $display("FAIL reset_bus_timeout: got %b expected 0", bus_timeout); end
`endif
        reset = 1'b0;
        repeat (4) step();
        n_cmp++; if (bus_busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: got busy %b expected 0", bus_busy); end
        model_last = 1'b1;
    endtask

    task automatic test_single();
        busrq_n = 2'b10;
        step(); step();
        n_cmp++; if (cpu_busrq_n !== 1'b1) begin n_err++; $display("FAIL single_req_early: got %b expected 1", cpu_busrq_n); end
        step();
        n_cmp++; if (cpu_busrq_n !== 1'b0 || bus_busy !== 1'b1) begin n_err++; $display("FAIL single_req_cpu: got busrq %b busy %b expected 0 1", cpu_busrq_n, bus_busy); end
        step(); step();
        n_cmp++; if (busak_n !== 2'b11 || cpu_busrq_n !== 1'b0) begin n_err++; $display("FAIL single_wait_ack: got busak %b busrq %b expected 11 0", busak_n, cpu_busrq_n); end
        cpu_busak_n = 1'b0;
        step();
        n_cmp++; if (busak_n !== 2'b11) begin n_err++; $display("FAIL single_grant_early: got %b expected 11", busak_n); end
        step();
        n_cmp++; if (busak_n !== 2'b10 || grant_id !== 1'b0) begin n_err++; $display("FAIL single_grant: got busak %b id %b expected 10 0", busak_n, grant_id); end
        model_last = 1'b0;
        cpu_busak_n = 1'b1;
        repeat (4) step();
        n_cmp++; if (busak_n !== 2'b10) begin n_err++; $display("FAIL single_ack_drop_ignored: got %b expected 10", busak_n); end
        cpu_busak_n = 1'b0;
        step();
        busrq_n = 2'b11;
        step(); step();
        n_cmp++; if (busak_n !== 2'b10) begin n_err++; $display("FAIL single_release_early: got %b expected 10", busak_n); end
        step();
        n_cmp++; if (busak_n !== 2'b11 || cpu_busrq_n !== 1'b1 || bus_busy !== 1'b1) begin n_err++; $display("FAIL single_release: got busak %b busrq %b busy %b expected 11 1 1", busak_n, cpu_busrq_n, bus_busy); end
        step();
        cpu_busak_n = 1'b1;
        step();
        n_cmp++; if (bus_busy !== 1'b1) begin n_err++; $display("FAIL single_wait_cpu: got busy %b expected 1", bus_busy); end
        step();
        n_cmp++; if (bus_busy !== 1'b0 || cpu_busrq_n !== 1'b1) begin n_err++; $display("FAIL single_idle: got busy %b busrq %b expected 0 1", bus_busy, cpu_busrq_n); end
    endtask

    task automatic test_withdrawal();
        int bad;
        bad = 0;
        busrq_n = 2'b01;
        for (int k = 0; k < 4; k++) begin
            step();
            if (busak_n !== 2'b11) bad++;
        end
        busrq_n = 2'b11;
        for (int k = 0; k < 10; k++) begin
            step();
            if (busak_n !== 2'b11) bad++;
        end
        n_cmp++; if (cpu_busrq_n !== 1'b0 || bus_busy !== 1'b1) begin n_err++; $display("FAIL withdraw_req_cpu: got busrq %b busy %b expected 0 1", cpu_busrq_n, bus_busy); end
        cpu_busak_n = 1'b0;
        step();
        if (busak_n !== 2'b11) bad++;
        n_cmp++; if (cpu_busrq_n !== 1'b0) begin n_err++; $display("FAIL withdraw_ack_early: got %b expected 0", cpu_busrq_n); end
        step();
        if (busak_n !== 2'b11) bad++;
        n_cmp++; if (cpu_busrq_n !== 1'b1 || bus_busy !== 1'b1) begin n_err++; $display("FAIL withdraw_release: got busrq %b busy %b expected 1 1", cpu_busrq_n, bus_busy); end
        step();
        cpu_busak_n = 1'b1;
        step(); step();
        if (busak_n !== 2'b11) bad++;
        n_cmp++; if (bus_busy !== 1'b0) begin n_err++; $display("FAIL withdraw_idle: got busy %b expected 0", bus_busy); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL withdraw_no_grant: got %0d grant cycles expected 0", bad); end
    endtask

    task automatic test_round_robin();
        logic exp;
        logic saw_idle;
        int   wt;
        cpu_auto = 1'b1;
        busrq_n  = 2'b00;
        exp      = ~model_last;
        saw_idle = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wt = 0;
            while (busak_n === 2'b11 && wt < 100) begin
                step(); wt++;
                if (bus_busy === 1'b0) saw_idle = 1'b1;
            end
            n_cmp++; if (busak_n !== (exp ? 2'b01 : 2'b10) || grant_id !== exp) begin n_err++; $display("FAIL rr_grant%0d: got busak %b id %b expected id %b", g, busak_n, grant_id, exp); end
            n_cmp++; if (saw_idle !== 1'b1) begin n_err++; $display("FAIL rr_idle_gap%0d: got no idle cycle expected one", g); end
            model_last = exp;
            repeat (5) step();
            n_cmp++; if (busak_n === 2'b00 || busak_n !== (exp ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL rr_hold%0d: got %b", g, busak_n); end
            busrq_n[exp] = 1'b1;
            step();
            busrq_n[exp] = 1'b0;
            wt = 0;
            while (busak_n !== 2'b11 && wt < 20) begin
                step(); wt++;
                if (busak_n === 2'b00) begin n_cmp++; n_err++; $display("FAIL rr_both_granted: got 00 expected one-hot-low"); end
            end
            saw_idle = 1'b0;
            exp = ~exp;
        end
        busrq_n = 2'b11;
        wt = 0;
        while (bus_busy !== 1'b0 && wt < 50) begin step(); wt++; end
        n_cmp++; if (bus_busy !== 1'b0) begin n_err++; $display("FAIL rr_final_idle: got busy %b expected 0", bus_busy); end
    endtask

    task automatic test_reset_midgrant();
        int wt;
        cpu_auto = 1'b1;
        busrq_n  = 2'b01;
        wt = 0;
        while (busak_n !== 2'b01 && wt < 50) begin step(); wt++; end
        n_cmp++; if (busak_n !== 2'b01) begin n_err++; $display("FAIL rst_mid_pregrant: got %b expected 01", busak_n); end
        reset = 1'b1; busrq_n = 2'b11;
        step();
        n_cmp++; if (busak_n !== 2'b11 || cpu_busrq_n !== 1'b1 || bus_busy !== 1'b0 || grant_id !== 1'b0) begin n_err++; $display("FAIL rst_mid_outputs: got busak %b busrq %b busy %b id %b expected 11 1 0 0", busak_n, cpu_busrq_n, bus_busy, grant_id); end
        reset = 1'b0;
        model_last = 1'b1;
        repeat (3) step();
        busrq_n = 2'b00;
        wt = 0;
        while (busak_n === 2'b11 && wt < 50) begin step(); wt++; end
        n_cmp++; if (busak_n !== 2'b10) begin n_err++; $display("FAIL rst_mid_tie: got %b expected 10", busak_n); end
        model_last = 1'b0;
        busrq_n = 2'b11;
        wt = 0;
        while (bus_busy !== 1'b0 && wt < 50) begin step(); wt++; end
    endtask

    // Randomized requesters; every grant and release is checked against the
    // arbitration rules applied to the request history seen two edges earlier.
    task automatic test_random();
        int         ph [2];
        int         cnt [2];
        int         wt [2];
        logic [1:0] prev;
        logic [1:0] elig;
        logic       gid, exp, cur, saw_idle;
        int         ngrant, wt2;
        cpu_auto = 1'b1;
        busrq_n  = 2'b11;
        prev     = 2'b11;
        cur      = model_last;
        saw_idle = 1'b1;
        ngrant   = 0;
        for (int i = 0; i < 2; i++) begin ph[i] = 0; cnt[i] = $urandom_range(0, 6); wt[i] = 0; end
        for (int c = 0; c < 1500; c++) begin
            step();
            hist[c] = busrq_n;
            if (busak_n === 2'b00) begin n_cmp++; n_err++; $display("FAIL rand_both_granted: cycle %0d got 00", c); end
            if (bus_busy === 1'b0) saw_idle = 1'b1;
            if (prev == 2'b11 && busak_n !== 2'b11 && c >= 2) begin
                gid  = busak_n[0];
                elig = ~hist[c-2];
                if (elig == 2'b11) exp = ~model_last;
                else exp = elig[1];
                n_cmp++;
                if (elig == 2'b00 || gid !== exp || grant_id !== exp || saw_idle !== 1'b1) begin
                    n_err++;
                    $display("FAIL rand_grant: cycle %0d got busak %b id %b idle %b expected id %b (eligible %b)", c, busak_n, grant_id, saw_idle, exp, elig);
                end
                model_last = exp;
                cur        = exp;
                saw_idle   = 1'b0;
                ngrant++;
            end
            if (prev != 2'b11 && busak_n === 2'b11 && c >= 2) begin
                n_cmp++;
                if (hist[c-2][cur] !== 1'b1) begin n_err++; $display("FAIL rand_release: cycle %0d got release while requester %0d held expected hold", c, cur); end
            end
            prev = busak_n;
            for (int i = 0; i < 2; i++) begin
                case (ph[i])
                    0: begin
                        if (cnt[i] == 0) begin busrq_n[i] = 1'b0; ph[i] = 1; wt[i] = 0; end
                        else cnt[i] = cnt[i] - 1;
                    end
                    1: begin
                        if (busak_n[i] === 1'b0) begin ph[i] = 2; cnt[i] = $urandom_range(1, 8); end
                        else begin
                            wt[i] = wt[i] + 1;
                            if (wt[i] > 200) begin
                                n_cmp++; n_err++;
                                $display("FAIL rand_starved: requester %0d got no grant within 200 cycles", i);
                                busrq_n[i] = 1'b1; ph[i] = 0; cnt[i] = 3;
                            end
                        end
                    end
                    default: begin
                        if (cnt[i] == 0) begin busrq_n[i] = 1'b1; ph[i] = 0; cnt[i] = $urandom_range(3, 8); end
                        else cnt[i] = cnt[i] - 1;
                    end
                endcase
            end
        end
        n_cmp++; if (ngrant < 10) begin n_err++; $display("FAIL rand_grant_count: got %0d expected at least 10", ngrant); end
        busrq_n = 2'b11;
        wt2 = 0;
        while (bus_busy !== 1'b0 && wt2 < 50) begin step(); wt2++; end
        n_cmp++; if (bus_busy !== 1'b0) begin n_err++; $display("FAIL rand_final_idle: got busy %b expected 0", bus_busy); end
    endtask

`ifdef HC21_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int low0, pulses, regrant, wt;
        cpu_auto = 1'b1;
        busrq_n  = 2'b10;
        low0 = 0; pulses = 0; regrant = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (busak_n[0] === 1'b0) low0++;
            if (bus_timeout === 1'b1) begin
                pulses++;
                n_cmp++; if (busak_n !== 2'b11) begin n_err++; $display("FAIL timeout_coincident: got busak %b expected 11", busak_n); end
            end
        end
        n_cmp++; if (low0 !== c_to) begin n_err++; $display("FAIL timeout_length: got %0d cycles expected %0d", low0, c_to); end
        n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL timeout_pulses: got %0d expected 1", pulses); end
        for (int c = 0; c < 30; c++) begin
            step();
            if (busak_n !== 2'b11) regrant++;
        end
        n_cmp++; if (regrant !== 0 || bus_busy !== 1'b0) begin n_err++; $display("FAIL timeout_lockout: got %0d grant cycles busy %b expected 0 0", regrant, bus_busy); end
        busrq_n = 2'b11;
        repeat (4) step();
        busrq_n = 2'b10;
        wt = 0;
        while (busak_n === 2'b11 && wt < 50) begin step(); wt++; end
        n_cmp++; if (busak_n !== 2'b10) begin n_err++; $display("FAIL timeout_unlock: got %b expected 10", busak_n); end
        model_last = 1'b0;
        busrq_n = 2'b11;
        wt = 0;
        while (bus_busy !== 1'b0 && wt < 50) begin step(); wt++; end
    endtask
`else
    task automatic test_hold_forever();
        int bad, wt;
        cpu_auto = 1'b1;
        busrq_n  = 2'b10;
        wt = 0;
        while (busak_n === 2'b11 && wt < 50) begin step(); wt++; end
        n_cmp++; if (busak_n !== 2'b10) begin n_err++; $display("FAIL hold_grant: got %b expected 10", busak_n); end
        bad = 0;
        for (int c = 0; c < 10000; c++) begin
            step();
            if (busak_n !== 2'b10 || cpu_busrq_n !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL hold_no_release: got %0d dropped cycles expected 0", bad); end
        model_last = 1'b0;
        busrq_n = 2'b11;
        wt = 0;
        while (bus_busy !== 1'b0 && wt < 50) begin step(); wt++; end
        n_cmp++; if (bus_busy !== 1'b0) begin n_err++; $display("FAIL hold_final_idle: got busy %b expected 0", bus_busy); end
    endtask
`endif

    initial begin
        reset = 1'b1; busrq_n = 2'b11; cpu_busak_n = 1'b1; model_last = 1'b1;
        test_reset();
        test_single();
        test_withdrawal();
        test_round_robin();
        test_reset_midgrant();
        test_random();
`ifdef HC21_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hold_forever();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
